fft_stage_ctrl: RTL and testbench
=================================

# fft_stage_ctrl

Sequencer for the in-place radix-2 DIT FFT core. It walks every stage and butterfly, and for each butterfly issues the data-memory address pair (A, B) plus the twiddle ROM address with the per-stage stride already applied, so the ROM is used with unit stride. It sits between the top-level start/done control, the sample RAM and the butterfly datapath. It also inserts a drain gap between stages so in-place writes of one stage complete before the next stage reads.

## Interface
- FFT_LEN_LOG2, 10, log2 of transform length N; also the width L of the data addresses.
- PIPE_DEPTH, 4, butterfly read-to-write latency in cycles; drain length between stages (≥1).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin a transform; honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the final stage has drained.
- bf_valid  out  1  butterfly command valid.
- bf_ready  in  1  datapath accepts the command; transfer = bf_valid & bf_ready.
- bf_addr_a  out  L  address of the upper butterfly input/output.
- bf_addr_b  out  L  address of the lower butterfly input/output (= a + 2^s).
- tw_addr  out  16  twiddle ROM address, zero-extended.
- bf_stage  out  8  current stage index s, 0..L-1.
- ld_valid_in  in  1  input-sample strobe (FFT_CTRL_BITREV_EN only).
- ld_ready  out  1  high in LOAD (FFT_CTRL_BITREV_EN only).
- ld_addr  out  L  bit-reversed write address for the current sample (FFT_CTRL_BITREV_EN only).

## Operation
- States: IDLE, LOAD (macro only), RUN, DRAIN, FINISH.
- IDLE: start → RUN (or LOAD); s = 0, k = 0.
- RUN: butterfly index k in 0..N/2−1, half = 2^s.
  - j = k & (half−1), g = k >> s.
  - addr_a = g·2^(s+1) + j; addr_b = addr_a + half.
  - tw_addr = j << (L−1−s).
- On each transfer, k increments. On the transfer with k = N/2−1, the block enters DRAIN and deasserts bf_valid.
- DRAIN: counts PIPE_DEPTH cycles. Then, if s < L−1: s+1, k = 0, back to RUN. Otherwise: FINISH.
- FINISH: done = 1 and busy = 0 for one cycle, then IDLE.
- bf_valid, once high, stays high with stable addresses until the transfer occurs (no retraction while bf_ready is low).
- start outside IDLE: ignored, no effect on the sequence.
- Reset: every output 0, state IDLE, counters 0. Reset mid-transform abandons it; no done is emitted.
- Arithmetic is unsigned, with no wrap inside a stage. Counters are L bits wide; k is L−1 bits.

## Timing
- All outputs are registered.
- start at cycle t → busy and bf_valid at t+1 (no LOAD).
- With bf_ready held high, one butterfly is issued per cycle.
- Stage gap: last transfer at cycle c → DRAIN in cycles c+1..c+PIPE_DEPTH → next bf_valid (or done) at c+PIPE_DEPTH+1.
- Total with ready high: 1 + L·(N/2 + PIPE_DEPTH) cycles from start to done.
- bf_ready low only stalls; it never reorders or skips commands.

## Configuration
- FFT_CTRL_BITREV_EN defined:
  - The LOAD state exists; start → LOAD.
  - ld_ready = 1 in LOAD. Each ld_valid_in increments the sample count n, and ld_addr = bitrev_L(n) is presented in the same cycle as the strobe.
  - After N samples, the block goes to RUN at the next cycle.
  - busy is high throughout LOAD.
- FFT_CTRL_BITREV_EN undefined:
  - The ld_* ports and the LOAD state are absent; ld_ready is not driven.
  - start goes directly to RUN, and input is expected to be pre-ordered.

## Structure
- Shared package fft_pkg holds:
  - the state enum;
  - the FFT_LEN_LOG2 default;
  - the TW_ADDR_W = 16 constant;
  - the bitrev function.
- Sub-module fft_addr_gen: a pure function of (s, k) producing addr_a, addr_b and tw_addr. The controller registers its outputs.

## Test plan
- L=3, PIPE_DEPTH=2, ready high, start at cycle 0 → the following transfers occur:
  - stage 0, k=0: (a0, b1, tw0); k=3: (a6, b7, tw0);
  - stage 1, k=1: (a1, b3, tw2); k=2: (a4, b6, tw0);
  - stage 2, k=3: (a3, b7, tw3);
  - 12 transfers in total, done at cycle 19.
- Same config, bf_ready low for 3 cycles mid-stage-1 → bf_valid and addresses held constant; done slips to cycle 22.
- Start pulsed again during RUN → no change in the sequence or in done timing.
- rst_n low at cycle 8 → next cycle all outputs 0 and state IDLE; no done; a new start restarts from s=0, k=0.
- L=10, PIPE_DEPTH=4 → 5120 transfers; max tw_addr = 511; every address pair satisfies b − a = 2^s; done at cycle 5161.
- FFT_CTRL_BITREV_EN, L=3 → samples 0..7 map to ld_addr 0,4,2,6,1,5,3,7; first bf_valid one cycle after the 8th sample.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT stage sequencer.
// FFT_CTRL_BITREV_EN adds the LOAD state used for bit-reversed sample loading.
package fft_pkg;

    localparam int FFT_LEN_LOG2_DEF = 10;
    localparam int TW_ADDR_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
`ifdef FFT_CTRL_BITREV_EN
        ST_LOAD   = 3'd1,
`endif
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } fft_state_e;

    // Reverse the low 'width' bits of 'value'; bits above 'width' come out as zero.
    function automatic logic [15:0] bitrev(input logic [15:0] value, input int width);
        logic [15:0] rev;
        rev = 16'd0;
        for (int i = 0; i < 16; i++) begin
            if (i < width) begin
                rev[4'(width - 1 - i)] = value[4'(i)];
            end else begin
                rev = rev;
            end
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address generator: pure combinational map (stage s, index k) to
// the upper/lower data addresses and the unit-stride twiddle ROM address.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int L = FFT_LEN_LOG2_DEF
) (
    input  logic [L-1:0]           s,
    input  logic [L-2:0]           k,
    output logic [L-1:0]           addr_a,
    output logic [L-1:0]           addr_b,
    output logic [TW_ADDR_W-1:0]   tw_addr
);

    localparam logic [L-1:0] ONE_L = L'(1);
    localparam logic [L-1:0] LM1_L = L'(L - 1);

    logic [L-1:0] k_ext_s;
    logic [L-1:0] half_s;
    logic [L-1:0] j_s;
    logic [L-1:0] g_s;

    // Split k into group and in-group offset, then place the pair and scale the twiddle index.
    always_comb begin
        k_ext_s = {1'b0, k};
        half_s  = ONE_L << s;
        j_s     = k_ext_s & (half_s - ONE_L);
        g_s     = k_ext_s >> s;
        addr_a  = ((g_s << s) << 1) | j_s;
        addr_b  = addr_a + half_s;
        tw_addr = TW_ADDR_W'(j_s << (LM1_L - s));
    end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for the in-place radix-2 DIT FFT core.
// Issues one butterfly command per accepted transfer, drains PIPE_DEPTH cycles
// between stages and pulses done after the last stage has drained.
// Optional macro FFT_CTRL_BITREV_EN: adds a LOAD phase producing bit-reversed
// sample write addresses before the first stage.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int FFT_LEN_LOG2 = FFT_LEN_LOG2_DEF,
    parameter int PIPE_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      bf_valid,
    input  logic                      bf_ready,
    output logic [FFT_LEN_LOG2-1:0]   bf_addr_a,
    output logic [FFT_LEN_LOG2-1:0]   bf_addr_b,
    output logic [TW_ADDR_W-1:0]      tw_addr,
    output logic [7:0]                bf_stage
`ifdef FFT_CTRL_BITREV_EN
    ,
    input  logic                      ld_valid_in,
    output logic                      ld_ready,
    output logic [FFT_LEN_LOG2-1:0]   ld_addr
`endif
);

    localparam int L  = FFT_LEN_LOG2;
    localparam int KW = L - 1;
    localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    localparam logic [L-1:0]  S_ZERO = {L{1'b0}};
    localparam logic [L-1:0]  S_ONE  = L'(1);
    localparam logic [L-1:0]  S_LAST = L'(L - 1);
    localparam logic [KW-1:0] K_ZERO = {KW{1'b0}};
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
    localparam logic [DW-1:0] D_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_LAST = DW'(PIPE_DEPTH - 1);

    fft_state_e          state_r, state_nxt_s;
    logic [L-1:0]        s_r, s_nxt_s;
    logic [KW-1:0]       k_r, k_nxt_s;
    logic [DW-1:0]       drain_r, drain_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                done_r, done_nxt_s;
    logic                bf_valid_r, bf_valid_nxt_s;
    logic [L-1:0]        addr_a_r, addr_b_r;
    logic [TW_ADDR_W-1:0] tw_r;
    logic [L-1:0]        gen_a_s, gen_b_s;
    logic [TW_ADDR_W-1:0] gen_tw_s;
`ifdef FFT_CTRL_BITREV_EN
    logic [L-1:0]        n_r, n_nxt_s;
    logic                ld_ready_r, ld_ready_nxt_s;
    logic [L-1:0]        ld_addr_r;
`endif

    // Addresses are computed for the command that will be presented next cycle.
    fft_addr_gen #(.L(L)) u_addr_gen (
        .s       (s_nxt_s),
        .k       (k_nxt_s),
        .addr_a  (gen_a_s),
        .addr_b  (gen_b_s),
        .tw_addr (gen_tw_s)
    );

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        s_nxt_s        = s_r;
        k_nxt_s        = k_r;
        drain_nxt_s    = drain_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        bf_valid_nxt_s = bf_valid_r;
`ifdef FFT_CTRL_BITREV_EN
        n_nxt_s        = n_r;
        ld_ready_nxt_s = ld_ready_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    s_nxt_s    = S_ZERO;
                    k_nxt_s    = K_ZERO;
                    busy_nxt_s = 1'b1;
`ifdef FFT_CTRL_BITREV_EN
                    state_nxt_s    = ST_LOAD;
                    n_nxt_s        = S_ZERO;
                    ld_ready_nxt_s = 1'b1;
`else
                    state_nxt_s    = ST_RUN;
                    bf_valid_nxt_s = 1'b1;
`endif
                end else begin
                    busy_nxt_s     = 1'b0;
                    bf_valid_nxt_s = 1'b0;
                end
            end
`ifdef FFT_CTRL_BITREV_EN
            ST_LOAD: begin
                if (ld_valid_in) begin
                    n_nxt_s = n_r + S_ONE;
                    if (n_r == {L{1'b1}}) begin
                        state_nxt_s    = ST_RUN;
                        ld_ready_nxt_s = 1'b0;
                        bf_valid_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    n_nxt_s = n_r;
                end
            end
`endif
            ST_RUN: begin
                if (bf_ready) begin
                    if (k_r == K_LAST) begin
                        state_nxt_s    = ST_DRAIN;
                        bf_valid_nxt_s = 1'b0;
                        drain_nxt_s    = D_ZERO;
                    end else begin
                        k_nxt_s = k_r + K_ONE;
                    end
                end else begin
                    k_nxt_s = k_r;
                end
            end
            ST_DRAIN: begin
                if (drain_r == D_LAST) begin
                    drain_nxt_s = D_ZERO;
                    k_nxt_s     = K_ZERO;
                    if (s_r == S_LAST) begin
                        state_nxt_s = ST_FINISH;
                        done_nxt_s  = 1'b1;
                        busy_nxt_s  = 1'b0;
                        s_nxt_s     = S_ZERO;
                    end else begin
                        state_nxt_s    = ST_RUN;
                        s_nxt_s        = s_r + S_ONE;
                        bf_valid_nxt_s = 1'b1;
                    end
                end else begin
                    drain_nxt_s = drain_r + D_ONE;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                s_nxt_s        = S_ZERO;
                k_nxt_s        = K_ZERO;
                drain_nxt_s    = D_ZERO;
                busy_nxt_s     = 1'b0;
                bf_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; addresses load only with a new command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            s_r        <= S_ZERO;
            k_r        <= K_ZERO;
            drain_r    <= D_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bf_valid_r <= 1'b0;
            addr_a_r   <= S_ZERO;
            addr_b_r   <= S_ZERO;
            tw_r       <= {TW_ADDR_W{1'b0}};
`ifdef FFT_CTRL_BITREV_EN
            n_r        <= S_ZERO;
            ld_ready_r <= 1'b0;
            ld_addr_r  <= S_ZERO;
`endif
        end else begin
            state_r    <= state_nxt_s;
            s_r        <= s_nxt_s;
            k_r        <= k_nxt_s;
            drain_r    <= drain_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            bf_valid_r <= bf_valid_nxt_s;
            if (bf_valid_nxt_s) begin
                addr_a_r <= gen_a_s;
                addr_b_r <= gen_b_s;
                tw_r     <= gen_tw_s;
            end else begin
                addr_a_r <= addr_a_r;
                addr_b_r <= addr_b_r;
                tw_r     <= tw_r;
            end
`ifdef FFT_CTRL_BITREV_EN
            n_r        <= n_nxt_s;
            ld_ready_r <= ld_ready_nxt_s;
            ld_addr_r  <= L'(bitrev(16'(n_nxt_s), L));
`endif
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign bf_valid  = bf_valid_r;
    assign bf_addr_a = addr_a_r;
    assign bf_addr_b = addr_b_r;
    assign tw_addr   = tw_r;
    assign bf_stage  = 8'(s_r);
`ifdef FFT_CTRL_BITREV_EN
    assign ld_ready  = ld_ready_r;
    assign ld_addr   = ld_addr_r;
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl: a small (L=3, PIPE_DEPTH=2) and a
// full-size (L=10, PIPE_DEPTH=4) instance, compared against a transfer-stream
// model built from nested group/offset loops.
module tb_fft_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n    = 1'b0;
    logic start    = 1'b0;
    logic bf_ready = 1'b0;
    logic sel      = 1'b0;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic        s_busy, s_done, s_valid;
    logic [2:0]  s_a, s_b;
    logic [15:0] s_tw;
    logic [7:0]  s_stage;
    logic        l_busy, l_done, l_valid;
    logic [9:0]  l_a, l_b;
    logic [15:0] l_tw;
    logic [7:0]  l_stage;
`ifdef FFT_CTRL_BITREV_EN
    logic        ld_valid = 1'b0;
    logic        s_ld_ready, l_ld_ready;
    logic [2:0]  s_ld_addr;
    logic [9:0]  l_ld_addr;
`endif

    fft_stage_ctrl #(.FFT_LEN_LOG2(3), .PIPE_DEPTH(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel),
        .busy(s_busy), .done(s_done), .bf_valid(s_valid), .bf_ready(bf_ready),
        .bf_addr_a(s_a), .bf_addr_b(s_b), .tw_addr(s_tw), .bf_stage(s_stage)
`ifdef FFT_CTRL_BITREV_EN
        , .ld_valid_in(ld_valid & ~sel), .ld_ready(s_ld_ready), .ld_addr(s_ld_addr)
`endif
    );

    fft_stage_ctrl #(.FFT_LEN_LOG2(10), .PIPE_DEPTH(4)) dut_l (
        .clk(clk), .rst_n(rst_n), .start(start & sel),
        .busy(l_busy), .done(l_done), .bf_valid(l_valid), .bf_ready(bf_ready),
        .bf_addr_a(l_a), .bf_addr_b(l_b), .tw_addr(l_tw), .bf_stage(l_stage)
`ifdef FFT_CTRL_BITREV_EN
        , .ld_valid_in(ld_valid & sel), .ld_ready(l_ld_ready), .ld_addr(l_ld_addr)
`endif
    );

    logic        o_busy, o_done, o_valid;
    logic [15:0] o_a, o_b, o_tw;
    logic [7:0]  o_stage;
    assign o_busy  = sel ? l_busy  : s_busy;
    assign o_done  = sel ? l_done  : s_done;
    assign o_valid = sel ? l_valid : s_valid;
    assign o_a     = sel ? 16'(l_a) : 16'(s_a);
    assign o_b     = sel ? 16'(l_b) : 16'(s_b);
    assign o_tw    = sel ? l_tw    : s_tw;
    assign o_stage = sel ? l_stage : s_stage;
`ifdef FFT_CTRL_BITREV_EN
    logic        o_ld_ready;
    logic [15:0] o_ld_addr;
    assign o_ld_ready = sel ? l_ld_ready : s_ld_ready;
    assign o_ld_addr  = sel ? 16'(l_ld_addr) : 16'(s_ld_addr);
`endif

    // Count one comparison and report it when the observed value differs.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int bitrev_ref(input int v, input int l);
        int r = 0;
        int x = v;
        for (int i = 0; i < l; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, ".busy"},  o_busy,  0);
        check_eq({tag, ".done"},  o_done,  0);
        check_eq({tag, ".valid"}, o_valid, 0);
        check_eq({tag, ".a"},     o_a,     0);
        check_eq({tag, ".b"},     o_b,     0);
        check_eq({tag, ".tw"},    o_tw,    0);
        check_eq({tag, ".stage"}, o_stage, 0);
    endtask

    // Pulse start (and, with the bit-reverse option, feed all N samples).
    task automatic kick(input int l);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
`ifdef FFT_CTRL_BITREV_EN
        begin
            int cnt = 0;
            int guard = 0;
            while (cnt < (1 << l) && guard < 8 * (1 << l) + 100) begin
                @(negedge clk);
                check_eq("ld_ready", o_ld_ready, 1);
                check_eq("ld_busy", o_busy, 1);
                check_eq("ld_addr", o_ld_addr, bitrev_ref(cnt, l));
                ld_valid = ($urandom_range(0, 2) != 0);
                @(posedge clk);
                #1;
                if (ld_valid) cnt++;
                ld_valid = 1'b0;
                guard++;
            end
            check_eq("ld_count", cnt, 1 << l);
        end
`endif
    endtask

    // One transform. mode 0: ready high plus stray starts; 1: 3-cycle stall in stage 1; 2: random.
    task automatic run_xfer(input int l, input int p, input int mode,
                            output int done_cyc, output int xfers, output int max_tw);
        int n = 1 << l;
        int total = l * (n / 2);
        int q_a[$], q_b[$], q_t[$], q_s[$];
        int idx = 0;
        int gap = 0;
        int limit;
        logic ev, ed, rdy, reached;
        for (int s = 0; s < l; s++) begin
            int half = 1 << s;
            for (int g = 0; g < n / (2 * half); g++) begin
                for (int j = 0; j < half; j++) begin
                    q_a.push_back(g * 2 * half + j);
                    q_b.push_back(g * 2 * half + j + half);
                    q_t.push_back(j * (n / (2 * half)));
                    q_s.push_back(s);
                end
            end
        end
        done_cyc = -1;
        xfers    = 0;
        max_tw   = 0;
        reached  = 1'b0;
        limit    = total * 8 + l * p + 50;
        kick(l);
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            ev = (gap == 0 && idx < total);
            ed = (gap == 0 && idx == total);
            check_eq("bf_valid", o_valid, ev);
            check_eq("done", o_done, ed);
            check_eq("busy", o_busy, !ed);
            if (ev) begin
                check_eq("addr_a", o_a, q_a[0]);
                check_eq("addr_b", o_b, q_b[0]);
                check_eq("tw_addr", o_tw, q_t[0]);
                check_eq("stage", o_stage, q_s[0]);
            end
            if (o_done) done_cyc = cyc;
            if (ed) begin
                reached = 1'b1;
                start = 1'b0;
                bf_ready = 1'b0;
                break;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = !(cyc >= 8 && cyc <= 10);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            bf_ready = rdy;
            case (mode)
                0: start = (cyc == 3 || cyc == 9);
                2: start = ($urandom_range(0, 15) == 0);
                default: start = 1'b0;
            endcase
            if (o_valid && rdy) begin
                xfers++;
                if (int'(o_tw) > max_tw) max_tw = int'(o_tw);
            end
            if (ev && rdy) begin
                void'(q_a.pop_front());
                void'(q_b.pop_front());
                void'(q_t.pop_front());
                void'(q_s.pop_front());
                idx++;
                if (idx % (n / 2) == 0) gap = p;
            end else if (!ev && gap > 0) begin
                gap--;
            end
        end
        check_eq("reached_done", reached, 1);
        @(negedge clk);
        check_eq("idle.done", o_done, 0);
        check_eq("idle.busy", o_busy, 0);
        check_eq("idle.valid", o_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, xf, mt;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b0;
        check_outputs_zero("rst_s");
        sel = 1'b1;
        check_outputs_zero("rst_l");
        rst_n = 1'b1;
        sel = 1'b0;

        run_xfer(3, 2, 0, dc, xf, mt);
        check_eq("s0.done_cyc", dc, 19);
        check_eq("s0.xfers", xf, 12);
        check_eq("s0.max_tw", mt, 3);

        run_xfer(3, 2, 1, dc, xf, mt);
        check_eq("s1.done_cyc", dc, 22);
        check_eq("s1.xfers", xf, 12);

        // Reset in the middle of a transform abandons it silently.
        kick(3);
        bf_ready = 1'b1;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midrst");
        rst_n = 1'b1;
        bf_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_eq("post_rst.done", o_done, 0);
            check_eq("post_rst.valid", o_valid, 0);
        end

        run_xfer(3, 2, 0, dc, xf, mt);
        check_eq("restart.done_cyc", dc, 19);

        for (int r = 0; r < 3; r++) begin
            run_xfer(3, 2, 2, dc, xf, mt);
            check_eq("rand.xfers", xf, 12);
        end

        sel = 1'b1;
        run_xfer(10, 4, 0, dc, xf, mt);
        check_eq("l.done_cyc", dc, 5161);
        check_eq("l.xfers", xf, 5120);
        check_eq("l.max_tw", mt, 511);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
